// File: rtl/nonlinear_round_controller_if.sv
// rtl/nonlinear_round_controller_if.sv - block request/response handshake bundle for the round controller
interface nonlinear_round_controller_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [N-1:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  // Requester / consumer side
  modport master (
    output in_valid,
    output in_data,
    output in_key,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Controller side
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_key,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/nonlinear_round_controller.sv
// rtl/nonlinear_round_controller.sv - iterative multi-round nonlinear cipher engine with in-flight key schedule
module nonlinear_round_controller #(
  parameter int N      = 8,
  parameter int ROUNDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nonlinear_round_controller_if.slave io,
  output logic                      busy,
  output logic [7:0]                round_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Index of the final round; the counter holds here through DONE.
  localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);

  state_e       fsm_q, fsm_d;
  logic [N-1:0] data_q, data_d;
  logic [N-1:0] key_q, key_d;
  logic [7:0]   idx_q, idx_d;

  logic [N-1:0] mix;
  logic [N-1:0] round_out;
  logic [N-1:0] key_next;

  // Nonlinear round: whiten with the key, then fold in the key-gated upper neighbour bit.
  always_comb begin
    mix       = data_q ^ key_q;
    round_out = '0;
    for (int i = 0; i < N; i++) begin
      round_out[i] = mix[i] ^ (mix[(i + 1) % N] & key_q[i]);
    end
  end

  // Key schedule: rotate left by one and mix in the round number (truncated or zero-extended to N).
  always_comb begin
    key_next = {key_q[N-2:0], key_q[N-1]} ^ N'(idx_q);
  end

  // Next-state and handshake outputs; outputs depend on the state register only.
  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    key_d  = key_q;
    idx_d  = idx_q;

    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    busy         = 1'b1;

    case (fsm_q)
      ST_IDLE: begin
        io.in_ready = 1'b1;
        busy        = 1'b0;
        if (io.in_valid) begin
          data_d = io.in_data;
          key_d  = io.in_key;
          idx_d  = 8'd0;
          fsm_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        data_d = round_out;
        key_d  = key_next;
        if (idx_q == LAST_IDX) begin
          fsm_d = ST_DONE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      ST_DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) begin
          idx_d = 8'd0;
          fsm_d = ST_IDLE;
        end
      end

      default: begin
        fsm_d = ST_IDLE;
        idx_d = 8'd0;
      end
    endcase
  end

  // The ciphertext is the state register itself; it lingers in IDLE until the next block loads.
  always_comb begin
    io.out_data = data_q;
    round_idx   = idx_q;
  end

  // State, datapath and key registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= ST_IDLE;
      data_q <= '0;
      key_q  <= '0;
      idx_q  <= 8'd0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      key_q  <= key_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: tb/tb_nonlinear_round_controller.sv
// tb/tb_nonlinear_round_controller.sv - self-checking bench for nonlinear_round_controller at ROUNDS 4, 1 and 2
module tb_nonlinear_round_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] kin;
  logic       in_valid_v [3];
  logic       out_ready_v [3];
  logic       ov [3];
  logic       ir [3];
  logic       bz [3];
  logic [7:0] od [3];
  logic [7:0] ri [3];
  int         cyc;
  int         total;
  int         bad;

  typedef struct {
    logic [7:0] d;
    logic [7:0] k;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e4;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [7:0] model(input logic [7:0] d_in, input logic [7:0] k_in, input int rounds);
    logic [7:0] d, k, x, y;
    d = d_in;
    k = k_in;
    for (int r = 0; r < rounds; r++) begin
      x = d ^ k;
      for (int i = 0; i < 8; i++) y[i] = x[i] ^ (x[(i + 1) % 8] & k[i]);
      d = y;
      k = {k[6:0], k[7]} ^ 8'(r);
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int RG = (g == 0) ? 4 : ((g == 1) ? 1 : 2);

    nonlinear_round_controller_if #(.N(8)) bus ();

    logic [7:0] exp_q [$];
    int         acc_cyc;
    logic       ov_d;

    assign bus.in_valid  = in_valid_v[g];
    assign bus.in_data   = din;
    assign bus.in_key    = kin;
    assign bus.out_ready = out_ready_v[g];
    assign ov[g]         = bus.out_valid;
    assign ir[g]         = bus.in_ready;
    assign od[g]         = bus.out_data;

    nonlinear_round_controller #(.N(8), .ROUNDS(RG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .io        (bus.slave),
      .busy      (bz[g]),
      .round_idx (ri[g])
    );

    initial begin
      acc_cyc = 0;
      ov_d    = 1'b0;
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        ov_d <= 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.in_data, bus.in_key, RG));
          acc_cyc <= cyc;
        end
        if (bz[g] && !bus.out_valid)
          chk($sformatf("r%0d_round_idx", RG), ri[g], cyc - acc_cyc - 1);
        if (bus.out_valid && !ov_d) begin
          chk($sformatf("r%0d_latency", RG), cyc - acc_cyc, RG + 1);
          chk($sformatf("r%0d_done_idx", RG), ri[g], RG - 1);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("r%0d_unexpected_out", RG), 1, 0);
          end else begin
            chk($sformatf("r%0d_scoreboard", RG), bus.out_data, exp_q.pop_front());
          end
        end
        ov_d <= bus.out_valid;
      end
    end
  end

  initial begin
    logic [7:0] held;
    logic       seen [3];
    logic [7:0] expv;
    int         prev;
    int         got;
    int         ovc;

    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    din   = 8'h00;
    kin   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b0;
    end

    tbl[0] = '{8'hAA, 8'hFF, 8'hFF, 8'h00, 8'hC0};
    tbl[1] = '{8'h55, 8'h00, 8'h55, 8'h55, 8'h54};
    for (int v = 2; v < 6; v++) begin
      tbl[v].d  = 8'($urandom);
      tbl[v].k  = 8'($urandom);
      tbl[v].e1 = model(tbl[v].d, tbl[v].k, 1);
      tbl[v].e2 = model(tbl[v].d, tbl[v].k, 2);
      tbl[v].e4 = model(tbl[v].d, tbl[v].k, 4);
    end

    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", ir[i], 1);
      chk("reset_out_valid", ov[i], 0);
      chk("reset_busy", bz[i], 0);
      chk("reset_out_data", od[i], 0);
      chk("reset_round_idx", ri[i], 0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven vectors, applied to all three round counts at once.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      #1;
      din = tbl[v].d;
      kin = tbl[v].k;
      for (int i = 0; i < 3; i++) begin
        in_valid_v[i]  = 1'b1;
        out_ready_v[i] = 1'b1;
        seen[i]        = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) in_valid_v[i] = 1'b0;
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (ov[i] && !seen[i]) begin
            expv    = (i == 0) ? tbl[v].e4 : ((i == 1) ? tbl[v].e1 : tbl[v].e2);
            seen[i] = 1'b1;
            chk($sformatf("vec%0d_dut%0d_out", v, i), od[i], expv);
          end
        end
      end
      for (int i = 0; i < 3; i++) chk($sformatf("vec%0d_dut%0d_seen", v, i), seen[i], 1);
    end

    // Backpressure on the ROUNDS=4 engine with a pending request held high.
    @(posedge clk);
    #1;
    din = 8'($urandom);
    kin = 8'($urandom);
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b0;
    @(posedge clk);
    #1;
    din = 8'($urandom);
    kin = 8'($urandom);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (ov[0]) break;
    end
    chk("bp_reach_done", ov[0], 1);
    held = od[0];
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("bp_out_stable", od[0], held);
      chk("bp_in_ready_low", ir[0], 0);
      chk("bp_out_valid_high", ov[0], 1);
    end
    @(posedge clk);
    #1 out_ready_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", ir[0], 1);
    chk("bp_idle_busy", bz[0], 0);
    chk("bp_idle_out_valid", ov[0], 0);
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (ov[0]) begin
        got = 1;
        break;
      end
    end
    chk("bp_pending_result", got, 1);
    repeat (2) @(posedge clk);

    // Back-to-back blocks: acceptances must be ROUNDS+2 cycles apart.
    @(posedge clk);
    #1;
    din = 8'($urandom);
    kin = 8'($urandom);
    in_valid_v[0]  = 1'b1;
    out_ready_v[0] = 1'b1;
    prev = 0;
    got  = 0;
    for (int t = 0; t < 60 && got < 5; t++) begin
      @(negedge clk);
      if (ir[0]) begin
        if (got > 0) chk("b2b_interval", cyc - prev, 6);
        prev = cyc;
        got++;
        @(posedge clk);
        #1;
        din = 8'($urandom);
        kin = 8'($urandom);
        if (got == 5) in_valid_v[0] = 1'b0;
      end
    end
    chk("b2b_blocks", got, 5);
    in_valid_v[0] = 1'b0;
    repeat (8) @(posedge clk);

    // Reset in the middle of RUN: block discarded, outputs back to reset values at once.
    #1;
    din = 8'($urandom) | 8'h01;
    kin = 8'($urandom);
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", ir[0], 1);
    chk("midrst_out_valid", ov[0], 0);
    chk("midrst_busy", bz[0], 0);
    chk("midrst_out_data", od[0], 0);
    chk("midrst_round_idx", ri[0], 0);
    gd[0].exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ovc = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ov[0]) ovc++;
    end
    chk("midrst_no_output", ovc, 0);

    chk("drain_q0", gd[0].exp_q.size(), 0);
    chk("drain_q1", gd[1].exp_q.size(), 0);
    chk("drain_q2", gd[2].exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
